// File: rtl/seg7_scan_driver_if.sv
// Bus between the digit source and the seven-segment scan driver.
// Load is a one-cycle strobe with no back-pressure: every asserted cycle is captured, and there is no ready.
interface seg7_scan_driver_if;
  logic [15:0] Digit_data;
  logic [3:0]  Dp_in;
  logic [3:0]  Digit_enable;
  logic        Load;
  logic [3:0]  Anode_sel;
  logic [7:0]  Digital_light;
  logic        Frame_done;
  logic        scan_show;

  modport master (
    output Digit_data, Dp_in, Digit_enable, Load,
    input  Anode_sel, Digital_light, Frame_done, scan_show
  );

  modport slave (
    input  Digit_data, Dp_in, Digit_enable, Load,
    output Anode_sel, Digital_light, Frame_done, scan_show
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// It uses a dwell/blank scan, a shadow register and optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4,
  parameter int LZ_BLANK  = 1
) (
  input logic                Up_clk,
  input logic                Up_reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int MAX_CNT = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_data;
  logic [3:0]    sh_dp;
  logic [3:0]    sh_en;

  logic [15:0]   cur_data;
  logic [3:0]    cur_dp;
  logic [3:0]    cur_en;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          dark;
  logic [3:0]    an_next;
  logic [7:0]    seg_next;

  // Active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // A Load on the same edge as BLANK->SHOW bypasses the shadow, so the new value shows in this slot.
  always_comb begin
    cur_data   = bus.Load ? bus.Digit_data   : sh_data;
    cur_dp     = bus.Load ? bus.Dp_in        : sh_dp;
    cur_en     = bus.Load ? bus.Digit_enable : sh_en;
    nib        = cur_data[{idx, 2'b00} +: 4];
    upper_zero = (cur_data >> {idx, 2'b00}) == 16'd0;
    dark       = !cur_en[idx] ||
                 ((LZ_BLANK != 0) && (idx != 2'd0) && upper_zero && !cur_dp[idx]);
    an_next    = dark ? 4'hF : ~(4'b0001 << idx);
    seg_next   = dark ? 8'hFF : {~cur_dp[idx], hex_seg(nib)};
  end

  assign bus.scan_show = (state == SHOW);

  always_ff @(posedge Up_clk or negedge Up_reset) begin
    if (!Up_reset) begin
      state             <= BLANK;
      cnt               <= '0;
      idx               <= 2'd0;
      sh_data           <= 16'd0;
      sh_dp             <= 4'd0;
      sh_en             <= 4'd0;
      bus.Anode_sel     <= 4'hF;
      bus.Digital_light <= 8'hFF;
      bus.Frame_done    <= 1'b0;
    end else begin
      bus.Frame_done <= 1'b0;
      if (bus.Load) begin
        sh_data <= bus.Digit_data;
        sh_dp   <= bus.Dp_in;
        sh_en   <= bus.Digit_enable;
      end
      case (state)
        BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            state             <= SHOW;
            cnt               <= '0;
            bus.Anode_sel     <= an_next;
            bus.Digital_light <= seg_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            state             <= BLANK;
            cnt               <= '0;
            idx               <= idx + 2'd1;
            bus.Anode_sel     <= 4'hF;
            bus.Digital_light <= 8'hFF;
            bus.Frame_done    <= (idx == 2'd3);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule
